// File: rtl/pixel_arbiter.sv
// pixel_arbiter: round-robin arbiter granting one pixel writer at a time to the VGA write port.
// Define PIXEL_ARB_TIMEOUT_EN to add a grant-hold timeout and the tmo_pulse output.
module pixel_arbiter #(
  parameter int NCLIENT = 4,
  parameter int nX      = 10,
  parameter int nY      = 9,
  parameter int NC      = 9,
  parameter int TMO     = 4096
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NCLIENT-1:0]    req,
  input  logic [NCLIENT*nX-1:0] c_x,
  input  logic [NCLIENT*nY-1:0] c_y,
  input  logic [NCLIENT*NC-1:0] c_color,
  input  logic [NCLIENT-1:0]    c_write,
  output logic [NCLIENT-1:0]    gnt,
  output logic [nX-1:0]         VGA_x,
  output logic [nY-1:0]         VGA_y,
  output logic [NC-1:0]         VGA_color,
  output logic                  VGA_write,
  output logic [2:0]            owner,
  output logic                  busy
`ifdef PIXEL_ARB_TIMEOUT_EN
  ,
  output logic                  tmo_pulse
`endif
);

  localparam int IW = $clog2(NCLIENT);

  if (NCLIENT < 2 || NCLIENT > 8 || TMO < 2) begin : g_param_check
    $error("pixel_arbiter: NCLIENT must be 2..8 and TMO at least 2");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state_r, state_n;
  logic [NCLIENT-1:0]  gnt_n;
  logic [2:0]          owner_n;
  logic                busy_n;
  logic [IW-1:0]       last_r, last_n, sel_s;
  logic                found_s, req_own_s;
`ifdef PIXEL_ARB_TIMEOUT_EN
  localparam int HW = $clog2(TMO);
  logic [HW-1:0]       hold_r, hold_n;
  logic                tmo_n;
`endif

  // Round-robin pick: scan downward so the nearest index after last_r wins.
  always_comb begin
    logic [IW-1:0] idx_v;
    idx_v   = '0;
    sel_s   = '0;
    found_s = 1'b0;
    for (int k = NCLIENT; k >= 1; k--) begin
      idx_v   = IW'((int'(last_r) + k) % NCLIENT);
      sel_s   = req[idx_v] ? idx_v : sel_s;
      found_s = found_s | req[idx_v];
    end
  end

  // gnt is one-hot on the owner, so this is the owner's request.
  assign req_own_s = |(req & gnt);

  // Next-state and next-grant logic.
  always_comb begin
    state_n = state_r;
    gnt_n   = gnt;
    owner_n = owner;
    busy_n  = busy;
    last_n  = last_r;
`ifdef PIXEL_ARB_TIMEOUT_EN
    hold_n  = hold_r;
    tmo_n   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_n = GRANT;
          gnt_n   = NCLIENT'(1) << sel_s;
          owner_n = 3'(sel_s);
          last_n  = sel_s;
          busy_n  = 1'b1;
`ifdef PIXEL_ARB_TIMEOUT_EN
          hold_n  = '0;
`endif
        end else begin
          gnt_n  = '0;
          busy_n = 1'b0;
        end
      end
      GRANT: begin
        if (!req_own_s) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
        end else begin
`ifdef PIXEL_ARB_TIMEOUT_EN
          if (hold_r == HW'(TMO - 1)) begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
            tmo_n   = 1'b1;
          end else begin
            hold_n = hold_r + HW'(1);
          end
`else
          state_n = GRANT;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and grant registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= IDLE;
      gnt       <= '0;
      owner     <= 3'd0;
      busy      <= 1'b0;
      last_r    <= IW'(NCLIENT - 1);
`ifdef PIXEL_ARB_TIMEOUT_EN
      hold_r    <= '0;
      tmo_pulse <= 1'b0;
`endif
    end else begin
      state_r   <= state_n;
      gnt       <= gnt_n;
      owner     <= owner_n;
      busy      <= busy_n;
      last_r    <= last_n;
`ifdef PIXEL_ARB_TIMEOUT_EN
      hold_r    <= hold_n;
      tmo_pulse <= tmo_n;
`endif
    end
  end

  // AND-OR mux keyed on gnt: only the owner's signals can reach the port.
  always_comb begin
    VGA_x     = '0;
    VGA_y     = '0;
    VGA_color = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      VGA_x     = VGA_x     | ({nX{gnt[i]}} & c_x[i*nX +: nX]);
      VGA_y     = VGA_y     | ({nY{gnt[i]}} & c_y[i*nY +: nY]);
      VGA_color = VGA_color | ({NC{gnt[i]}} & c_color[i*NC +: NC]);
    end
    VGA_write = |(gnt & c_write);
  end

endmodule
